// File: rtl/eq_sweep_pkg.sv
// Shared types and helpers for the eq_sweep_checker sweep engine.
// Optional Gray-code sweep order is selected by EQ_SWEEP_GRAY_EN in eq_sweep_checker.
package eq_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MAX_N_IN = 16;

  function automatic int holdCntW(input int hold);
    return $clog2(hold + 1);
  endfunction

  function automatic int mismatchCntW(input int nIn);
    return nIn + 1;
  endfunction

  // Callers truncate the result back to their own vector width.
  function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/eq_sweep_cmp.sv
// Compares every implementation channel against channel 0 (the reference).
module eq_sweep_cmp
  import eq_sweep_pkg::*;
#(
  parameter int N_CH = 3
) (
  input  logic [N_CH-1:0] ch_in,
  output logic            mismatch,
  output logic [N_CH-1:0] mask
);

  assign mask     = ch_in ^ {N_CH{ch_in[0]}};
  assign mismatch = |mask;

endmodule

// File: rtl/eq_sweep_checker.sv
// Exhaustive sweep engine: drives all 2^N_IN vectors to N_CH channels and checks them against channel 0.
// Define EQ_SWEEP_GRAY_EN to sweep in Gray-code order instead of ascending binary.
module eq_sweep_checker
  import eq_sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_CH = 3,
  parameter int HOLD = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic [N_CH-1:0] ch_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [N_CH-1:0] first_fail_mask,
  output logic            first_fail_valid
);

  localparam int HW = holdCntW(HOLD);
  localparam int MW = mismatchCntW(N_IN);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;
  localparam logic [MW-1:0]   MCNT_MAX  = {1'b1, {N_IN{1'b0}}};

  state_e state_q, state_d;

  logic [N_IN-1:0] vecIdx_q, vecIdx_d;
  logic [HW-1:0]   holdCnt_q, holdCnt_d;
  logic [MW-1:0]   mismatchCnt_q, mismatchCnt_d;
  logic [N_IN-1:0] firstFailVec_q, firstFailVec_d;
  logic [N_CH-1:0] firstFailMask_q, firstFailMask_d;
  logic            firstFailValid_q, firstFailValid_d;

  logic [N_IN-1:0] vecCode;
  logic            sampleNow;
  logic            startAccept;
  logic            mismatch;
  logic [N_CH-1:0] mask;

  eq_sweep_cmp #(
    .N_CH(N_CH)
  ) u_cmp (
    .ch_in   (ch_in),
    .mismatch(mismatch),
    .mask    (mask)
  );

`ifdef EQ_SWEEP_GRAY_EN
  assign vecCode = N_IN'(bin2gray(MAX_N_IN'(vecIdx_q)));
`else
  assign vecCode = vecIdx_q;
`endif

  assign sampleNow   = (state_q == APPLY) && (holdCnt_q == HOLD_LAST);
  assign startAccept = start && (state_q != APPLY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   if (sampleNow && (vecIdx_q == IDX_LAST)) state_d = DONE;
      DONE:    if (start) state_d = APPLY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == APPLY);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (mismatchCnt_q == '0);
  end

  // A fresh sweep (or idling) wipes every result so nothing leaks between runs.
  always_comb begin
    vecIdx_d         = vecIdx_q;
    holdCnt_d        = holdCnt_q;
    mismatchCnt_d    = mismatchCnt_q;
    firstFailVec_d   = firstFailVec_q;
    firstFailMask_d  = firstFailMask_q;
    firstFailValid_d = firstFailValid_q;
    if (startAccept || (state_q == IDLE)) begin
      vecIdx_d         = '0;
      holdCnt_d        = '0;
      mismatchCnt_d    = '0;
      firstFailVec_d   = '0;
      firstFailMask_d  = '0;
      firstFailValid_d = 1'b0;
    end else if (state_q == APPLY) begin
      if (sampleNow) begin
        holdCnt_d = '0;
        vecIdx_d  = vecIdx_q + 1'b1;
        if (mismatch) begin
          if (mismatchCnt_q != MCNT_MAX) mismatchCnt_d = mismatchCnt_q + 1'b1;
          if (!firstFailValid_q) begin
            firstFailVec_d   = vecCode;
            firstFailMask_d  = mask;
            firstFailValid_d = 1'b1;
          end
        end
      end else begin
        holdCnt_d = holdCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vecIdx_q         <= '0;
      holdCnt_q        <= '0;
      mismatchCnt_q    <= '0;
      firstFailVec_q   <= '0;
      firstFailMask_q  <= '0;
      firstFailValid_q <= 1'b0;
    end else begin
      vecIdx_q         <= vecIdx_d;
      holdCnt_q        <= holdCnt_d;
      mismatchCnt_q    <= mismatchCnt_d;
      firstFailVec_q   <= firstFailVec_d;
      firstFailMask_q  <= firstFailMask_d;
      firstFailValid_q <= firstFailValid_d;
    end
  end

  assign vec_out          = vecCode;
  assign mismatch_cnt     = mismatchCnt_q;
  assign first_fail_vec   = firstFailVec_q;
  assign first_fail_mask  = firstFailMask_q;
  assign first_fail_valid = firstFailValid_q;

endmodule

// File: doc/eq_sweep_checker.md
# eq_sweep_checker

Hardware self-checking sweep engine for small combinational functions. On `start` it drives every one of the 2^N_IN input vectors to N_CH parallel implementations of the same function, such as gate-level, dataflow and UDP variants. It samples each implementation's output and compares every channel against channel 0. It reports a pass/fail verdict, the number of mismatching vectors, and the first failing vector. It sits between a stimulus-free top level and the implementations under comparison, and is the synthesizable, parametrised successor to hand-written fixed-vector benches.

## Interface
Parameters:
- `N_IN`, default 4: input vector width; the sweep covers 2^N_IN vectors; legal range 1..16.
- `N_CH`, default 3: number of implementation channels; channel 0 is the golden reference; legal range 2..32.
- `HOLD`, default 2: clock cycles each vector is held before sampling; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- `vec_out`  out  N_IN  vector currently applied to all channels.
- `ch_in`  in  N_CH  one output bit per implementation; bit 0 is the reference.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep completion until the next accepted `start` or reset.
- `pass`  out  1  valid while `done`; 1 iff `mismatch_cnt == 0`.
- `mismatch_cnt`  out  N_IN+1  number of vectors where any channel differed from channel 0; saturates at 2^N_IN.
- `first_fail_vec`  out  N_IN  first vector that mismatched, in sweep order.
- `first_fail_mask`  out  N_CH  channels that differed at `first_fail_vec`; bit 0 is always 0.
- `first_fail_valid`  out  1  high once a mismatch has been recorded in the current or last sweep.

## Operation
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - On `start`, go to APPLY.
  - Clear the vector index, hold counter, `mismatch_cnt`, `first_fail_*` and `done`.
- APPLY:
  - `vec_out` is the code of the current index (see Configuration).
  - The hold counter counts 0..HOLD-1.
  - On the cycle the hold counter equals HOLD-1, the block samples `ch_in`.
  - Mismatch is defined as `|(ch_in ^ {N_CH{ch_in[0]}})`.
  - On a mismatch, increment `mismatch_cnt`.
  - On a mismatch with `first_fail_valid` still 0, capture `vec_out` and the mismatch mask, then set `first_fail_valid`.
  - After sampling, advance the index. After sampling the last index (2^N_IN-1), go to DONE.
- DONE:
  - `done` = 1 and `busy` = 0; all results are held.
  - On `start`, clear the results and return to APPLY at index 0. `start` therefore works as a re-run.
- `start` while in APPLY is ignored.
- `ch_in` is sampled directly. The implementations are assumed to settle within HOLD cycles, so HOLD=1 requires the combinational path to settle in one cycle.

## Timing
- Reset values:
  - `vec_out` = 0, `busy` = 0, `done` = 0, `pass` = 0
  - `mismatch_cnt` = 0, `first_fail_vec` = 0, `first_fail_mask` = 0, `first_fail_valid` = 0
  - state = IDLE
- `start` is seen at edge k. From edge k+1: `busy` = 1 and `vec_out` = vector 0.
- Each vector is presented for exactly HOLD cycles, with no gap between vectors.
- Total sweep length is 2^N_IN × HOLD cycles.
- `done` and `pass` rise at the edge after the final sample, and `busy` falls on that same edge.
- The final vector's mismatch is already reflected in `mismatch_cnt` when `done` rises.
- Reset asserted mid-sweep: at the next edge the block returns to IDLE with all outputs at their reset values. No partial results are retained.
- `start` coincident with `rst_n` = 0: reset wins.

## Configuration
- `EQ_SWEEP_GRAY_EN` defined: `vec_out` = Gray(index), so exactly one input bit toggles per vector step. This exercises hazard-free transitions. `first_fail_vec` reports the Gray-coded vector.
- Not defined: `vec_out` = index, i.e. ascending binary order 0, 1, 2, …
- Both modes cover all 2^N_IN vectors exactly once.

## Structure
- Package `eq_sweep_pkg`:
  - state enum (IDLE/APPLY/DONE)
  - function `bin2gray`
  - width helper constants: counter width `$clog2(HOLD+1)`, and `N_IN+1` for `mismatch_cnt`.
- Sub-module `eq_sweep_cmp`, purely combinational, parametrised on N_CH. Takes `ch_in` and produces `mismatch` plus `mask`.
- The top module holds the FSM, index counter, hold counter and result registers.

## Test plan
- All channels tied to the same 4-input function, defaults: `start` → `busy` for 32 cycles, then `done` = 1, `pass` = 1, `mismatch_cnt` = 0, `first_fail_valid` = 0.
- Channel 2 wrong only at vector 4'b0101, binary mode: `mismatch_cnt` = 1, `first_fail_vec` = 5, `first_fail_mask` = 3'b100, `pass` = 0.
- Channel 1 inverted from channel 0 at every vector: `mismatch_cnt` = 16, `first_fail_vec` = 0, `first_fail_mask` = 3'b010.
- `EQ_SWEEP_GRAY_EN`, HOLD = 1: `vec_out` sequence is 0, 1, 3, 2, 6, … with Hamming distance 1 between consecutive vectors, and `done` rises after 16 cycles.
- `rst_n` = 0 at cycle 10 of a sweep, then `start` again: outputs return to their reset values, and the new sweep's results match a clean run.
- `start` pulsed again mid-sweep: ignored, total length still 32 cycles. `start` in DONE: results cleared and the sweep reruns.
